sponge_perm_scheduler: RTL and testbench
========================================

SPONGE_PERM_SCHEDULER -- requirements
Module: sponge_perm_scheduler

Interface
REQ-001 Parameter CWIDTH, default 320: capacity/state width carried to and from the permutation engine.
REQ-002 Parameter RWIDTH, default 32: rate word width returned by the engine.
REQ-003 Parameter ROUND_COUNT, default 10: width of the rounds field.
REQ-004 Parameter TIMEOUT, default 1023: maximum RUN cycles before abort; watchdog counter is 10 bits.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, deasserted synchronously to clk.
REQ-007 req0, req1  in  1 each  permutation request from absorb (0) and squeeze (1) controllers.
REQ-008 c0, c1  in  CWIDTH each  capacity input per requester.
REQ-009 rounds0, rounds1  in  ROUND_COUNT each  round count per requester.
REQ-010 gnt0, gnt1  out  1 each  requester owns engine.
REQ-011 done0, done1  out  1 each  one-cycle completion pulse to owner.
REQ-012 c_out  out  CWIDTH; r_out  out  RWIDTH  registered result, shared by both requesters.
REQ-013 err  out  1  timeout flag, valid with doneX.
REQ-014 g_go  out  1  engine enable; engine is held in reset while 0.
REQ-015 g_c  out  CWIDTH; g_rounds  out  ROUND_COUNT  latched operands to engine.
REQ-016 g_done  in  1; g_cout  in  CWIDTH; g_rout  in  RWIDTH  engine results.

Function
REQ-017 FSM states IDLE, LAUNCH, RUN, RESP; reset state IDLE.
REQ-018 IDLE: if neither req, stay; if one req, select it; if both, select the requester not recorded as last-served (round-robin); after reset, last-served = 1, so requester 0 wins first tie.
REQ-019 On selection in IDLE: latch owner, g_c <= cX, g_rounds <= roundsX; next LAUNCH.
REQ-020 Selected rounds == 0: skip engine; c_out <= cX, r_out <= cX[CWIDTH-1 -: RWIDTH], err <= 0; next RESP directly.
REQ-021 LAUNCH: g_go = 1, watchdog cleared to 0; next RUN.
REQ-022 RUN: g_go = 1; watchdog increments each cycle; on g_done = 1 latch c_out <= g_cout, r_out <= g_rout, err <= 0, next RESP.
REQ-023 RUN watchdog equals TIMEOUT with g_done = 0: err <= 1, c_out/r_out unchanged, next RESP; g_done takes priority when both occur same cycle.
REQ-024 RESP: g_go = 0 (engine reset); doneX = 1 for owner only, exactly one cycle; last-served <= owner; next IDLE.
REQ-025 gntX = 1 for owner from LAUNCH (or RESP on bypass) through RESP inclusive; gnt0 and gnt1 never both 1.
REQ-026 Latency: req sampled in IDLE at edge N -> LAUNCH N+1 -> RUN N+2; doneX asserted the cycle after g_done is sampled high.
REQ-027 req deasserted mid-operation is ignored; operation completes and done still pulses.
REQ-028 req held high through RESP is re-arbitrated in the following IDLE cycle (min 1 IDLE cycle between grants).
REQ-029 Operand inputs cX/roundsX changing after latch do not affect the running operation.
REQ-030 g_done outside RUN is ignored.

Reset
REQ-031 reset = 0: state IDLE, gnt0/1, done0/1, err, g_go = 0; c_out, r_out, g_c, g_rounds, watchdog = 0; last-served = 1.
REQ-032 reset asserted mid-RUN aborts without doneX; g_go drops asynchronously, holding the engine in reset.

Verification
REQ-033 req0 alone, c0 = 0x1, rounds0 = 10, engine model g_done after 12 cycles -> gnt0 = 1, g_go high 13 cycles, done0 one pulse, c_out = model g_cout, err = 0.
REQ-034 req0 and req1 same cycle after reset, both held -> grants ordered 0,1,0,1; never simultaneous gnt.
REQ-035 rounds1 = 0, c1 = 0xABC -> g_go stays 0, done1 pulse 2 cycles after request, c_out = 0xABC, r_out = upper RWIDTH bits of c1.
REQ-036 Engine never asserts g_done, TIMEOUT = 15 -> done pulse with err = 1 after 15 RUN cycles, c_out retains prior value.
REQ-037 reset pulsed low during RUN -> all outputs 0 immediately, no done pulse, next req0 wins tie.
REQ-038 g_done pulsed while IDLE, then req1 -> spurious pulse ignored, normal completion on its own g_done.

Source files
------------

// File: rtl/sponge_perm_scheduler.sv
// Arbitrates two sponge controllers onto one permutation engine and returns its result.
// Latency: request sampled in IDLE -> LAUNCH -> RUN (rounds cycles) -> RESP; rounds==0 goes straight to RESP.
// Backpressure: requesters hold req until done; a busy engine leaves the other request pending.
module sponge_perm_scheduler #(
  parameter int CWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int ROUND_COUNT = 10,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [CWIDTH-1:0]      c0,
  input  logic [CWIDTH-1:0]      c1,
  input  logic [ROUND_COUNT-1:0] rounds0,
  input  logic [ROUND_COUNT-1:0] rounds1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   done0,
  output logic                   done1,
  output logic [CWIDTH-1:0]      c_out,
  output logic [RWIDTH-1:0]      r_out,
  output logic                   err,
  output logic                   g_go,
  output logic [CWIDTH-1:0]      g_c,
  output logic [ROUND_COUNT-1:0] g_rounds,
  input  logic                   g_done,
  input  logic [CWIDTH-1:0]      g_cout,
  input  logic [RWIDTH-1:0]      g_rout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Watchdog compare is done one bit wider so the increment never wraps before the compare.
  localparam logic [10:0] TO_LIM = 11'(TIMEOUT);

  state_t                 state_q;
  logic                   owner_q;
  logic                   last_q;
  logic [9:0]             wd_q;
  logic                   gnt0_q, gnt1_q, done0_q, done1_q, err_q, g_go_q;
  logic [CWIDTH-1:0]      c_out_q, g_c_q;
  logic [RWIDTH-1:0]      r_out_q;
  logic [ROUND_COUNT-1:0] g_rounds_q;

  logic                   pick1_d;
  logic [CWIDTH-1:0]      sel_c_d;
  logic [ROUND_COUNT-1:0] sel_rounds_d;
  logic [10:0]            wd_inc_d;

  // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    pick1_d      = req1 & (~req0 | ~last_q);
    sel_c_d      = pick1_d ? c1 : c0;
    sel_rounds_d = pick1_d ? rounds1 : rounds0;
    wd_inc_d     = {1'b0, wd_q} + 11'd1;
  end

  // Scheduler FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      wd_q       <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      g_go_q     <= 1'b0;
      c_out_q    <= '0;
      r_out_q    <= '0;
      g_c_q      <= '0;
      g_rounds_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0 | req1) begin
            owner_q    <= pick1_d;
            g_c_q      <= sel_c_d;
            g_rounds_q <= sel_rounds_d;
            gnt0_q     <= ~pick1_d;
            gnt1_q     <= pick1_d;
            if (sel_rounds_d == '0) begin
              // Zero rounds is the identity permutation: answer without waking the engine.
              c_out_q <= sel_c_d;
              r_out_q <= sel_c_d[CWIDTH-1 -: RWIDTH];
              err_q   <= 1'b0;
              done0_q <= ~pick1_d;
              done1_q <= pick1_d;
              state_q <= S_RESP;
            end else begin
              g_go_q  <= 1'b1;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wd_q    <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (g_done) begin
            c_out_q <= g_cout;
            r_out_q <= g_rout;
            err_q   <= 1'b0;
            g_go_q  <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_RESP;
          end else if (wd_inc_d == TO_LIM) begin
            // Engine hung: report the abort and keep the previous result visible.
            err_q   <= 1'b1;
            g_go_q  <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_RESP;
          end else begin
            wd_q <= wd_q + 10'd1;
          end
        end
        S_RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign err      = err_q;
  assign g_go     = g_go_q;
  assign c_out    = c_out_q;
  assign r_out    = r_out_q;
  assign g_c      = g_c_q;
  assign g_rounds = g_rounds_q;

endmodule

// File: tb/tb_sponge_perm_scheduler.sv
// Bench for sponge_perm_scheduler: directed scenarios plus random traffic.
// A transaction-level model predicts grant/done/go timing and results each cycle.
// The engine stand-in finishes rounds+2 cycles after g_go rises.
module tb_sponge_perm_scheduler;
  localparam int CW = 320;
  localparam int RW = 32;
  localparam int RC = 10;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [CW-1:0] c0 = '0, c1 = '0;
  logic [RC-1:0] rounds0 = '0, rounds1 = '0;
  logic          gnt0, gnt1, done0, done1, err, g_go, g_done;
  logic [CW-1:0] c_out, g_c, g_cout;
  logic [RW-1:0] r_out, g_rout;
  logic [RC-1:0] g_rounds;
  logic          spur_done = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  sponge_perm_scheduler #(.CWIDTH(CW), .RWIDTH(RW), .ROUND_COUNT(RC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n), .req0(req0), .req1(req1), .c0(c0), .c1(c1),
    .rounds0(rounds0), .rounds1(rounds1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .c_out(c_out), .r_out(r_out), .err(err),
    .g_go(g_go), .g_c(g_c), .g_rounds(g_rounds), .g_done(g_done),
    .g_cout(g_cout), .g_rout(g_rout));

  always #5 clk = ~clk;

  // Engine stand-in: counts cycles with g_go high, done after rounds+2 of them.
  int eng_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng_cnt <= 0;
    else if (!g_go) eng_cnt <= 0;
    else eng_cnt <= eng_cnt + 1;
  end
  assign g_done = (g_go && (eng_cnt == int'(g_rounds) + 2)) || spur_done;
  assign g_cout = g_c + CW'(g_rounds);
  assign g_rout = ~g_c[RW-1:0];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_t counts cycles into the current grant (0 = idle), m_end is the response cycle.
  int            m_t = 0, m_end = 0;
  bit            m_byp, m_own, m_ok, m_err;
  bit            m_last = 1'b1;
  logic [CW-1:0] m_c, m_cout;
  logic [RW-1:0] m_rout;
  logic [RC-1:0] m_rounds;

  task automatic model_step();
    int lat;
    if (!rst_n) begin
      m_t = 0; m_last = 1'b1; m_cout = '0; m_rout = '0; m_err = 1'b0;
      m_c = '0; m_rounds = '0;
    end else if (m_t == 0) begin
      if (req0 || req1) begin
        m_own    = (req0 && req1) ? !m_last : req1;
        m_c      = m_own ? c1 : c0;
        m_rounds = m_own ? rounds1 : rounds0;
        m_t      = 1;
        if (m_rounds == 0) begin
          m_byp = 1'b1; m_end = 1;
          m_cout = m_c; m_rout = m_c[CW-1 -: RW]; m_err = 1'b0;
        end else begin
          m_byp = 1'b0;
          lat   = int'(m_rounds) + 2;
          m_ok  = (lat <= TO);
          m_end = (m_ok ? lat : TO) + 2;
        end
      end
    end else if (m_t == m_end) begin
      m_t = 0;
      m_last = m_own;
    end else begin
      m_t++;
      if (m_t == m_end) begin
        if (m_ok) begin
          m_cout = m_c + CW'(m_rounds); m_rout = ~m_c[RW-1:0]; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Compare process: every cycle out of reset, outputs against the model.
  initial forever begin
    bit busy, dn;
    @(negedge clk);
    if (rst_n) begin
      busy = (m_t > 0);
      dn   = busy && (m_t == m_end);
      chk("gnt0", CW'(gnt0), CW'(busy && !m_own));
      chk("gnt1", CW'(gnt1), CW'(busy && m_own));
      chk("done0", CW'(done0), CW'(dn && !m_own));
      chk("done1", CW'(done1), CW'(dn && m_own));
      chk("g_go", CW'(g_go), CW'(busy && !m_byp && m_t < m_end));
      chk("c_out", c_out, m_cout);
      chk("r_out", CW'(r_out), CW'(m_rout));
      if (dn) chk("err", CW'(err), CW'(m_err));
      if (busy) begin
        chk("g_c", g_c, m_c);
        chk("g_rounds", CW'(g_rounds), CW'(m_rounds));
      end
    end
  end

  // Activity counters and grant order log.
  int go_cnt = 0, d0_cnt = 0, d1_cnt = 0;
  bit p0 = 1'b0, p1 = 1'b0;
  bit gq[$];
  initial forever begin
    @(negedge clk);
    if (rst_n && g_go) go_cnt++;
    if (done0) d0_cnt++;
    if (done1) d1_cnt++;
    if (gnt0 && !p0) gq.push_back(1'b0);
    if (gnt1 && !p1) gq.push_back(1'b1);
    p0 = gnt0; p1 = gnt1;
  end

  function automatic logic [CW-1:0] rand_c();
    logic [CW-1:0] v;
    for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (!(done0 || done1) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) chk("wait_done_timeout", CW'(1), CW'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_gnt0", CW'(gnt0), CW'(0));
    chk("rst_gnt1", CW'(gnt1), CW'(0));
    chk("rst_go", CW'(g_go), CW'(0));
    chk("rst_err", CW'(err), CW'(0));
    chk("rst_cout", c_out, CW'(0));
    chk("rst_gc", g_c, CW'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, operands scrambled after latch, req dropped mid-operation.
    c0 = CW'(1); rounds0 = 10'd10; req0 = 1'b1;
    go_cnt = 0; d0_cnt = 0;
    @(negedge clk);
    req0 = 1'b0; c0 = rand_c(); rounds0 = 10'd200;
    wait_done(100);
    chk("t1_cout", c_out, CW'(11));
    chk("t1_rout", CW'(r_out), CW'(32'hFFFF_FFFE));
    chk("t1_err", CW'(err), CW'(0));
    @(negedge clk);
    chk("t1_go_cycles", CW'(go_cnt), CW'(13));
    chk("t1_done_pulses", CW'(d0_cnt), CW'(1));

    // Watchdog abort: engine would need 22 cycles.
    c0 = CW'(7); rounds0 = 10'd20; req0 = 1'b1; go_cnt = 0;
    @(negedge clk);
    req0 = 1'b0;
    wait_done(100);
    chk("t2_err", CW'(err), CW'(1));
    chk("t2_cout_kept", c_out, CW'(11));
    @(negedge clk);
    chk("t2_go_cycles", CW'(go_cnt), CW'(16));

    // Zero-round bypass.
    c1 = CW'(12'hABC); rounds1 = '0; req1 = 1'b1;
    @(negedge clk);
    chk("t3_done1", CW'(done1), CW'(1));
    chk("t3_go", CW'(g_go), CW'(0));
    chk("t3_cout", c_out, CW'(12'hABC));
    chk("t3_rout", CW'(r_out), CW'(0));
    req1 = 1'b0;
    @(negedge clk);
    chk("t3_done1_drop", CW'(done1), CW'(0));

    // Spurious engine done while idle, then a normal request.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    c1 = CW'(5); rounds1 = 10'd3; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    wait_done(50);
    chk("t4_done1", CW'(done1), CW'(1));
    chk("t4_cout", c_out, CW'(8));
    @(negedge clk);

    // Reset during RUN.
    c0 = CW'(3); rounds0 = 10'd10; req0 = 1'b1;
    repeat (4) @(negedge clk);
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_go", CW'(g_go), CW'(0));
    chk("t5_gnt0", CW'(gnt0), CW'(0));
    chk("t5_done0", CW'(done0), CW'(0));
    chk("t5_cout", c_out, CW'(0));
    chk("t5_gc", g_c, CW'(0));
    chk("t5_grounds", CW'(g_rounds), CW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
    // Simultaneous held requests: alternation starting with 0.
    rounds0 = 10'd1; rounds1 = 10'd1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("t6_first_gnt0", CW'(gnt0), CW'(1));
    for (int k = 0; k < 200 && gq.size() < 4; k++) @(negedge clk);
    if (gq.size() < 4) chk("t6_grant_count", CW'(gq.size()), CW'(4));
    else for (int i = 0; i < 4; i++) chk("t6_order", CW'(gq[i]), CW'(i % 2));
    req0 = 1'b0; req1 = 1'b0;
    repeat (30) @(negedge clk);

    // Random traffic.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      c0 = rand_c(); c1 = rand_c();
      rounds0 = ($urandom_range(0, 5) == 0) ? RC'(0) : RC'($urandom_range(1, 16));
      rounds1 = ($urandom_range(0, 5) == 0) ? RC'(0) : RC'($urandom_range(1, 16));
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
